skew_align_reg: RTL

Parametrised input-skew register bank for the systolic convolution array. It takes CH_NUM parallel lanes per cycle and delays lane k by a lane-dependent number of cycles, either staircase skew in front of the PE array or inverse de-skew behind it. Each lane is widened from DW_IN to DW_OUT by sign- or zero-extension. A per-lane valid travels with the data, and a global stall freezes the bank. After a tagged last beat, a drain FSM pushes bubbles until every lane has emitted its final element.

---
 rtl/skew_align_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/skew_align_reg.sv
// Per-lane staircase skew / de-skew register bank with lane widening, per-lane valid,
// a travelling last tag and a drain FSM that flushes the longest lane after a tile.
module skew_align_reg #(
   parameter int unsigned CH_NUM = 9,
   parameter int unsigned DW_IN  = 8,
   parameter int unsigned DW_OUT = 9,
   parameter bit          SIGNED = 1'b1,
   parameter bit          MODE   = 1'b0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     ce,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic [CH_NUM*DW_IN-1:0]  in_data,
   output logic                     in_ready,
   output logic [CH_NUM*DW_OUT-1:0] out_data,
   output logic [CH_NUM-1:0]        out_valid,
   output logic                     out_last,
   output logic                     busy
);

   localparam int unsigned CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             tag;

   assign in_ready = ce & (state_q != DRAIN);
   assign accept   = in_valid & in_ready;
   assign tag      = accept & in_last;
   assign busy     = (state_q != IDLE);

   // FSM state and drain counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (ce) begin
         unique case (state_q)
            IDLE, RUN: begin
               if (accept) begin
                  if (in_last) begin
                     if (CH_NUM > 1) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(CH_NUM - 1);
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            DRAIN: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // One delay chain per lane; bubbles carry zero data and valid 0
   for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
      localparam int unsigned DLY = MODE ? (CH_NUM - 1 - k) : k;

      logic [DW_IN-1:0]  lane_in;
      logic [DW_OUT-1:0] ext;
      logic [DW_OUT:0]   ins;

      assign lane_in = in_data[k*DW_IN +: DW_IN];

      if (DW_OUT > DW_IN) begin : g_ext
         assign ext = {{(DW_OUT-DW_IN){SIGNED & lane_in[DW_IN-1]}}, lane_in};
      end else begin : g_noext
         assign ext = lane_in;
      end

      assign ins = accept ? {1'b1, ext} : '0;

      if (DLY == 0) begin : g_comb
         assign out_valid[k]                  = ins[DW_OUT];
         assign out_data[k*DW_OUT +: DW_OUT]  = ins[DW_OUT-1:0];
      end else begin : g_chain
         logic [DLY-1:0][DW_OUT:0] sr_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               sr_q <= '0;
            end else if (clr) begin
               sr_q <= '0;
            end else if (ce) begin
               sr_q[0] <= ins;
               for (int i = 1; i < int'(DLY); i++) sr_q[i] <= sr_q[i-1];
            end
         end

         assign out_valid[k]                  = sr_q[DLY-1][DW_OUT];
         assign out_data[k*DW_OUT +: DW_OUT]  = sr_q[DLY-1][DW_OUT-1:0];
      end
   end

   // Last tag travels as far as the longest lane
   if (CH_NUM > 1) begin : g_last
      logic [CH_NUM-2:0] last_q;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            last_q <= '0;
         end else if (clr) begin
            last_q <= '0;
         end else if (ce) begin
            last_q[0] <= tag;
            for (int i = 1; i < int'(CH_NUM) - 1; i++) last_q[i] <= last_q[i-1];
         end
      end

      assign out_last = last_q[CH_NUM-2];
   end else begin : g_last_comb
      assign out_last = tag;
   end

endmodule
